range_finder_input_pio: RTL

Parametrised Avalon-MM input PIO. It samples an external input bus, for example the range-finder board switches and push-buttons, through a synchroniser and a per-bit debounce filter. It latches filtered edges in a write-1-to-clear capture register and raises a maskable level interrupt to the Nios II. It sits on the system interconnect as a slave with fixed one-cycle read latency.

---
 rtl/range_finder_pio_pkg.sv | 18 +
 rtl/pio_debounce_bit.sv | 62 ++++++
 rtl/range_finder_input_pio.sv | 81 ++++++++
 3 files changed

// File: rtl/range_finder_pio_pkg.sv
// Shared constants for the range-finder input PIO: register map, edge modes, counter sizing.
// No logic of its own; no latency and no backpressure.
package range_finder_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // A zero-cycle filter still needs a one-bit counter to keep the port legal.
    function automatic int debounce_cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit: synchroniser chain, debounce filter (f) and its one-cycle-delayed copy (fp).
// f follows in_bit after SYNC_STAGES (+filter) edges; no backpressure, always accepts input.
module pio_debounce_bit
    import range_finder_pio_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 0,
    parameter logic RESET_BIT       = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_bit,
    output logic f,
    output logic fp
);

    localparam int CW = debounce_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = (DEBOUNCE_CYCLES > 0) ? CW'(DEBOUNCE_CYCLES - 1) : '0;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   f_q, f_d;
    logic                   fp_q, fp_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], in_bit};
        fp_d   = f_q;
        f_d    = f_q;
        cnt_d  = '0;
        if (DEBOUNCE_CYCLES == 0) begin
            f_d = s;
        end else if (s != f_q) begin
            // Any return to s == f before the last count restarts the filter.
            if (cnt_q == CNT_LAST) begin
                f_d = s;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{RESET_BIT}};
            cnt_q  <= '0;
            f_q    <= RESET_BIT;
            fp_q   <= RESET_BIT;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            f_q    <= f_d;
            fp_q   <= fp_d;
        end
    end

    assign f  = f_q;
    assign fp = fp_q;

endmodule

// File: rtl/range_finder_input_pio.sv
// Avalon-MM input PIO: filtered inputs, W1C edge capture, maskable level irq.
// Read latency 1 (readdata registered every cycle); slave never stalls, no waitrequest.
module range_finder_input_pio
    import range_finder_pio_pkg::*;
#(
    parameter int               WIDTH           = 8,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 0,
    parameter int               EDGE_TYPE       = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] f, fp;
    logic [WIDTH-1:0] edge_evt, clr;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             writedata_unused;

    assign writedata_unused = ^writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_BIT      (RESET_VALUE[i])
        ) u_bit (
            .clk    (clk),
            .reset_n(reset_n),
            .in_bit (in_port[i]),
            .f      (f[i]),
            .fp     (fp[i])
        );
    end

    always_comb begin
        case (EDGE_TYPE)
            EDGE_FALLING: edge_evt = ~f & fp;
            EDGE_ANY:     edge_evt = f ^ fp;
            default:      edge_evt = f & ~fp;
        endcase

        clr = (write && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
        // OR-ing the edge in last lets a same-cycle edge beat the clear.
        cap_d  = (cap_q & ~clr) | edge_evt;
        mask_d = (write && address == ADDR_IRQMASK) ? writedata[WIDTH-1:0] : mask_q;

        readdata_d = '0;
        case (address)
            ADDR_DATA:    readdata_d[WIDTH-1:0] = f;
            ADDR_IRQMASK: readdata_d[WIDTH-1:0] = mask_q;
            ADDR_EDGECAP: readdata_d[WIDTH-1:0] = cap_q;
            default:      readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q     <= '0;
            cap_q      <= '0;
            readdata_q <= '0;
        end else begin
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(cap_q & mask_q);

endmodule
